// File: rtl/test_pattern_pkg.sv
// Shared constants for the VGA test-pattern generator: mode encodings and
// fixed pattern geometry.
package test_pattern_pkg;

    localparam logic [2:0] MODE_GRADIENT = 3'd0;
    localparam logic [2:0] MODE_BARS     = 3'd1;
    localparam logic [2:0] MODE_CHECKER  = 3'd2;
    localparam logic [2:0] MODE_SCROLL   = 3'd3;
    localparam logic [2:0] MODE_WHITE    = 3'd4;
    localparam logic [2:0] MODE_BORDER   = 3'd5;

    localparam int NUM_BARS      = 8;
    localparam int CHECKER_SHIFT = 5;

endpackage

// File: rtl/test_pattern_bar_index.sv
// Maps a pixel column onto one of NUM_BARS equal-width vertical bars using
// elaboration-time thresholds instead of a divider.
module test_pattern_bar_index
    import test_pattern_pkg::*;
#(
    parameter int COORD_BITS = 16,
    parameter int H_ACTIVE   = 640
) (
    input  logic [COORD_BITS-1:0] i_horz_coord,
    output logic [2:0]            o_bar_idx
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    // Last threshold crossed wins; thresholds ascend, so this is a priority chain.
    always_comb begin
        o_bar_idx = 3'd0;
        for (int k = 1; k < NUM_BARS; k++) begin
            if (i_horz_coord >= COORD_BITS'(k * BAR_W))
                o_bar_idx = 3'(k);
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Registered VGA test-pattern generator. Colour appears one pixel clock after
// the coordinates; the mode only changes on the frame-start pulse.
module test_pattern_gen
    import test_pattern_pkg::*;
#(
    parameter int COORD_BITS = 16,
    parameter int RED_BITS   = 3,
    parameter int GREEN_BITS = 3,
    parameter int BLUE_BITS  = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                  i_pix_clk,
    input  logic                  i_reset_n,
    input  logic [COORD_BITS-1:0] i_horz_coord,
    input  logic [COORD_BITS-1:0] i_vert_coord,
    input  logic                  i_in_active_area,
    input  logic                  i_frame_start,
    input  logic [2:0]            i_mode,
    output logic [RED_BITS-1:0]   o_red,
    output logic [GREEN_BITS-1:0] o_green,
    output logic [BLUE_BITS-1:0]  o_blue,
    output logic                  o_in_active_area,
    output logic [7:0]            o_frame_count,
    output logic [2:0]            o_mode
);

    logic [2:0]            mode_q;
    logic [7:0]            cnt_q;
    logic [RED_BITS-1:0]   red_q,   red_d;
    logic [GREEN_BITS-1:0] green_q, green_d;
    logic [BLUE_BITS-1:0]  blue_q,  blue_d;
    logic                  act_q;

    logic [COORD_BITS-1:0] h_scroll, h_grad;
    logic [2:0]            bar_idx;
    logic                  on_border;

    test_pattern_bar_index #(
        .COORD_BITS (COORD_BITS),
        .H_ACTIVE   (H_ACTIVE)
    ) u_bar_index (
        .i_horz_coord (i_horz_coord),
        .o_bar_idx    (bar_idx)
    );

    assign h_scroll  = i_horz_coord + COORD_BITS'(cnt_q);
    assign h_grad    = (mode_q == MODE_SCROLL) ? h_scroll : i_horz_coord;
    assign on_border = (i_horz_coord == '0) ||
                       (i_horz_coord == COORD_BITS'(H_ACTIVE - 1)) ||
                       (i_vert_coord == '0) ||
                       (i_vert_coord == COORD_BITS'(V_ACTIVE - 1));

    // Uses the registered mode/count, so a pixel coinciding with frame start
    // still renders with the previous frame's settings.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (i_in_active_area) begin
            case (mode_q)
                MODE_GRADIENT, MODE_SCROLL: begin
                    red_d   = h_grad[RED_BITS+3:4];
                    green_d = i_vert_coord[GREEN_BITS+3:4];
                    blue_d  = h_grad[BLUE_BITS+5:6] ^ i_vert_coord[BLUE_BITS+4:5];
                end
                MODE_BARS: begin
                    red_d   = bar_idx[1] ? '0 : '1;
                    green_d = bar_idx[2] ? '0 : '1;
                    blue_d  = bar_idx[0] ? '0 : '1;
                end
                MODE_CHECKER: begin
                    if (i_horz_coord[CHECKER_SHIFT] ^ i_vert_coord[CHECKER_SHIFT]) begin
                        red_d   = '1;
                        green_d = '1;
                        blue_d  = '1;
                    end
                end
                MODE_WHITE: begin
                    red_d   = '1;
                    green_d = '1;
                    blue_d  = '1;
                end
                MODE_BORDER: begin
                    if (on_border) begin
                        red_d   = '1;
                        green_d = '1;
                        blue_d  = '1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (!i_reset_n) begin
            mode_q  <= '0;
            cnt_q   <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            act_q   <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            act_q   <= i_in_active_area;
            if (i_frame_start) begin
                mode_q <= i_mode;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end

    assign o_red            = red_q;
    assign o_green          = green_q;
    assign o_blue           = blue_q;
    assign o_in_active_area = act_q;
    assign o_frame_count    = cnt_q;
    assign o_mode           = mode_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen at default parameters (3/3/2 colour, 640x480).
module tb_test_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] h, v;
    logic        act, fs;
    logic [2:0]  mode;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        act_o;
    logic [7:0]  fcnt;
    logic [2:0]  mode_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_pattern_gen dut (
        .i_pix_clk        (clk),
        .i_reset_n        (rst_n),
        .i_horz_coord     (h),
        .i_vert_coord     (v),
        .i_in_active_area (act),
        .i_frame_start    (fs),
        .i_mode           (mode),
        .o_red            (red),
        .o_green          (green),
        .o_blue           (blue),
        .o_in_active_area (act_o),
        .o_frame_count    (fcnt),
        .o_mode           (mode_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [2:0] m);
        fs = 1'b1; mode = m; act = 1'b0;
        tick();
        fs = 1'b0;
    endtask

    task automatic pix(input logic [15:0] hh, input logic [15:0] vv, input logic a);
        h = hh; v = vv; act = a;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fs = 1'b1; mode = 3'd4; h = 16'd5; v = 16'd5; act = 1'b1;
        tick(); tick();
        checks++;
        if ({red, green, blue} !== 8'h00) begin
            errors++; $display("FAIL reset_colour got %h want 00", {red, green, blue});
        end
        checks++;
        if (act_o !== 1'b0) begin errors++; $display("FAIL reset_act got %b want 0", act_o); end
        checks++;
        if (fcnt !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fcnt); end
        checks++;
        if (mode_o !== 3'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode_o); end
        rst_n = 1'b1; fs = 1'b0; act = 1'b0;
        tick();
    endtask

    task automatic test_gradient();
        frame(3'd0);
        checks++;
        if (mode_o !== 3'd0 || fcnt !== 8'd1) begin
            errors++; $display("FAIL grad_frame got mode %0d cnt %0d want 0 1", mode_o, fcnt);
        end
        pix(16'h35, 16'h52, 1'b1);
        checks++;
        if ({red, green, blue, act_o} !== {3'd3, 3'd5, 2'd2, 1'b1}) begin
            errors++; $display("FAIL gradient got r%0d g%0d b%0d a%b want r3 g5 b2 a1", red, green, blue, act_o);
        end
    endtask

    task automatic test_bars();
        logic [15:0] hv [6] = '{16'd0, 16'd79, 16'd80, 16'd160, 16'd400, 16'd639};
        logic [7:0]  ex [6] = '{{3'd7,3'd7,2'd3}, {3'd7,3'd7,2'd3}, {3'd7,3'd7,2'd0},
                                {3'd0,3'd7,2'd3}, {3'd7,3'd0,2'd0}, {3'd0,3'd0,2'd0}};
        frame(3'd1);
        for (int i = 0; i < 6; i++) begin
            pix(hv[i], 16'd10, 1'b1);
            checks++;
            if ({red, green, blue} !== ex[i]) begin
                errors++; $display("FAIL bars h=%0d got %h want %h", hv[i], {red, green, blue}, ex[i]);
            end
        end
        // New input must not show up before the next edge.
        h = 16'd0; #2;
        checks++;
        if ({red, green, blue} !== 8'h00) begin
            errors++; $display("FAIL bars_latency got %h want 00", {red, green, blue});
        end
        tick();
        checks++;
        if ({red, green, blue} !== 8'hFF) begin
            errors++; $display("FAIL bars_latency2 got %h want ff", {red, green, blue});
        end
    endtask

    task automatic test_mode_latch();
        frame(3'd2);
        mode = 3'd4;
        pix(16'd32, 16'd0, 1'b1);
        checks++;
        if ({red, green, blue} !== 8'hFF) begin
            errors++; $display("FAIL latch_chk_on got %h want ff", {red, green, blue});
        end
        pix(16'd0, 16'd0, 1'b1);
        checks++;
        if ({red, green, blue} !== 8'h00 || mode_o !== 3'd2) begin
            errors++; $display("FAIL latch_chk_off got %h mode %0d want 00 mode 2", {red, green, blue}, mode_o);
        end
        frame(3'd4);
        pix(16'd0, 16'd0, 1'b1);
        checks++;
        if ({red, green, blue} !== 8'hFF) begin
            errors++; $display("FAIL latch_white got %h want ff", {red, green, blue});
        end
        // Frame start on an active pixel: this pixel still white, mode 0 afterwards.
        fs = 1'b1; mode = 3'd0; h = 16'd0; v = 16'd0; act = 1'b1;
        tick();
        fs = 1'b0;
        checks++;
        if ({red, green, blue} !== 8'hFF || mode_o !== 3'd0) begin
            errors++; $display("FAIL coincide got %h mode %0d want ff mode 0", {red, green, blue}, mode_o);
        end
        pix(16'd0, 16'd0, 1'b1);
        checks++;
        if ({red, green, blue} !== 8'h00) begin
            errors++; $display("FAIL coincide_next got %h want 00", {red, green, blue});
        end
    endtask

    task automatic test_scroll();
        rst_n = 1'b0; act = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 16; i++) frame(3'd3);
        pix(16'd0, 16'd0, 1'b1);
        checks++;
        if ({red, green, blue} !== {3'd1, 3'd0, 2'd0}) begin
            errors++; $display("FAIL scroll16 got r%0d g%0d b%0d want r1 g0 b0", red, green, blue);
        end
        pix(16'h30, 16'd0, 1'b1);
        checks++;
        if ({red, green, blue} !== {3'd4, 3'd0, 2'd1}) begin
            errors++; $display("FAIL scroll16_h30 got r%0d g%0d b%0d want r4 g0 b1", red, green, blue);
        end
        for (int i = 16; i < 255; i++) frame(3'd3);
        checks++;
        if (fcnt !== 8'd255) begin errors++; $display("FAIL count255 got %0d want 255", fcnt); end
        frame(3'd3);
        checks++;
        if (fcnt !== 8'd0) begin errors++; $display("FAIL count_wrap got %0d want 0", fcnt); end
    endtask

    task automatic test_border();
        logic [15:0] hv [5] = '{16'd100, 16'd100, 16'd0, 16'd639, 16'd638};
        logic [15:0] vv [5] = '{16'd479, 16'd100, 16'd200, 16'd5, 16'd478};
        logic [7:0]  ex [5] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
        frame(3'd5);
        for (int i = 0; i < 5; i++) begin
            pix(hv[i], vv[i], 1'b1);
            checks++;
            if ({red, green, blue} !== ex[i]) begin
                errors++; $display("FAIL border h=%0d v=%0d got %h want %h", hv[i], vv[i], {red, green, blue}, ex[i]);
            end
        end
    endtask

    task automatic test_blank();
        for (int m = 0; m < 8; m++) begin
            frame(3'(m));
            pix(16'd0, 16'd0, 1'b0);
            checks++;
            if ({red, green, blue, act_o} !== 9'd0) begin
                errors++; $display("FAIL blank mode %0d got %h a%b want 00 a0", m, {red, green, blue}, act_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        frame(3'd4);
        pix(16'd10, 16'd10, 1'b1);
        checks++;
        if ({red, green, blue} !== 8'hFF) begin
            errors++; $display("FAIL pre_reset got %h want ff", {red, green, blue});
        end
        rst_n = 1'b0;
        pix(16'd11, 16'd10, 1'b1);
        checks++;
        if ({red, green, blue, act_o} !== 9'd0 || mode_o !== 3'd0 || fcnt !== 8'd0) begin
            errors++; $display("FAIL reset_mid got %h a%b mode %0d cnt %0d want 00 a0 mode 0 cnt 0",
                               {red, green, blue}, act_o, mode_o, fcnt);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; h = '0; v = '0; act = 1'b0; fs = 1'b0; mode = '0;
        test_reset();
        test_gradient();
        test_bars();
        test_mode_latch();
        test_scroll();
        test_border();
        test_blank();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_pattern_gen.md
# test_pattern_gen

Parametrised, registered VGA test-pattern generator with selectable patterns and per-frame animation. It sits between the VGA timing controller and the DAC/pin outputs. It consumes the controller's pixel coordinates and active-area flag and produces RGB colour one pixel clock later. The pattern mode changes only at frame boundaries, so the image never tears.

## Interface
- COORD_BITS, 16, width of coordinate inputs
- RED_BITS, 3, red channel width
- GREEN_BITS, 3, green channel width
- BLUE_BITS, 2, blue channel width
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
- V_ACTIVE, 480, visible lines per frame
- i_pix_clk  in  1  pixel clock; the block's only clock
- i_reset_n  in  1  synchronous, active-low reset
- i_horz_coord  in  COORD_BITS  current pixel column
- i_vert_coord  in  COORD_BITS  current pixel line
- i_in_active_area  in  1  high while the pixel is visible
- i_frame_start  in  1  one-cycle pulse once per frame, issued during blanking
- i_mode  in  3  requested pattern; sampled only on i_frame_start
- o_red  out  RED_BITS  red channel
- o_green  out  GREEN_BITS  green channel
- o_blue  out  BLUE_BITS  blue channel
- o_in_active_area  out  1  i_in_active_area delayed by 1 cycle
- o_frame_count  out  8  frame counter
- o_mode  out  3  currently latched mode

## Operation
- Reset (i_reset_n low at a clock edge):
  - o_red, o_green, o_blue, o_in_active_area, o_frame_count and o_mode all go to 0.
  - Reset takes priority over every other input.
  - Reset asserted mid-frame blanks the output from the next edge.
- On i_frame_start:
  - the mode register loads i_mode;
  - o_frame_count increments, wrapping from 255 to 0.
- i_mode changes between frame_start pulses are ignored.
- Colour generation:
  - "Full" means all ones in a channel.
  - h and v are the coordinates.
  - Colour is computed from the latched mode and registered.
  - When the delayed active flag is 0, all colour outputs are 0.
- Modes:
  - 0 GRADIENT:
    - red = h[RED_BITS+3:4]
    - green = v[GREEN_BITS+3:4]
    - blue = h[BLUE_BITS+5:6] XOR v[BLUE_BITS+4:5]
  - 1 BARS: eight vertical bars, each H_ACTIVE/8 wide.
    - Bar index b is 0..7, derived by comparison against elaboration-time thresholds; no divider.
    - red = full if b[1]==0, green = full if b[2]==0, blue = full if b[0]==0.
    - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
  - 2 CHECKER: 32x32 cells. All channels full when h[5] XOR v[5] is 1, else 0.
  - 3 SCROLL: same as GRADIENT, with h replaced by (h + o_frame_count) mod 2^COORD_BITS.
  - 4 WHITE: all channels full.
  - 5 BORDER: all channels full when h==0, h==H_ACTIVE-1, v==0 or v==V_ACTIVE-1; else 0.
  - 6, 7 reserved: output 0.
- Simultaneous events: if i_frame_start coincides with an active pixel, that pixel uses the old mode and count. The new values apply from the next cycle.
- Coordinates outside H_ACTIVE/V_ACTIVE with the active flag high are not checked. The pattern equations are simply applied.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- o_in_active_area tracks the colour outputs cycle for cycle, so the sync pipeline must add one matching register.
- o_mode and o_frame_count update on the edge that samples i_frame_start.
- No handshake: the block accepts one pixel every cycle and never stalls.

## Structure
- Shared package test_pattern_pkg holds:
  - mode constants MODE_GRADIENT=0, MODE_BARS=1, MODE_CHECKER=2, MODE_SCROLL=3, MODE_WHITE=4, MODE_BORDER=5;
  - NUM_BARS=8;
  - CHECKER_SHIFT=5.
- One sub-module, test_pattern_bar_index:
  - combinational h to 3-bit bar index;
  - parametrised by COORD_BITS and H_ACTIVE.
- Top level holds the mode register, frame counter, pattern mux and output register.

## Test plan
- Reset and gradient:
  - Hold i_reset_n low: all outputs 0.
  - Release, pulse frame_start with mode 0, then drive h=0x35, v=0x52, active=1.
  - One cycle later: red=3, green=5, blue=2, o_in_active_area=1.
- Bars:
  - Mode 1 at defaults.
  - h=0 gives (7,7,3); h=80 gives (7,7,0); h=639 gives (0,0,0).
  - Each result appears 1 cycle after input.
- Mode latch:
  - Mode 2 active; change i_mode to 4 mid-frame.
  - Output stays checker (h=32, v=0 gives full; h=0, v=0 gives 0) until the next frame_start, then becomes white.
- Frame count and scroll:
  - Issue 16 frame_starts in mode 3; h=0 then gives red=1.
  - After 256 total frame_starts, o_frame_count=0.
- Border and blanking:
  - Mode 5: v=479, h=100 gives full.
  - h=100, v=100 gives 0.
  - Any pixel with active=0 gives 0 in all modes.
- Reset mid-frame:
  - Assert i_reset_n low while in mode 4 with active=1.
  - Next cycle: colour 0, o_mode=0, o_frame_count=0.
